dram_master: RTL and testbench

Bus-initiator side of the SDRAM controller request interface. Accepts 16-bit halfword read/write strobes from the d16 core, issues 32-bit `req_read`/`req_write` transactions to `sdram_controller`, and returns read data with a one-cycle acknowledge. It holds one 32-bit word in a buffer, so repeated accesses to the same word skip DRAM. Halfword writes are performed as read-modify-write, because the controller has no byte or halfword mask.

---
 rtl/dram_master_pkg.sv | 39 +++
 rtl/dram_word_buffer.sv | 52 +++++
 rtl/dram_master.sv | 155 +++++++++++++++
 tb/tb_dram_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_master_pkg.sv
// dram_master_pkg
// Shared types, widths and helpers for the d16 SDRAM request initiator.
// Contents: FSM state enum, bus widths, timeout read-data constant,
// halfword merge/select helpers used by dram_master and dram_word_buffer.
package dram_master_pkg;

  localparam int DRAM_AW = 24;
  localparam int DRAM_DW = 32;
  localparam int CPU_AW  = 25;
  localparam int CPU_DW  = 16;

  // Read data returned with cpu_err on a timed-out access.
  localparam logic [CPU_DW-1:0] RDATA_TIMEOUT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_WR_FETCH,
    ST_WR_REQ,
    ST_DONE
  } state_t;

  // Replace one half of a 32-bit word; upper = 1 selects [31:16].
  function automatic logic [DRAM_DW-1:0] merge_half(
    input logic [DRAM_DW-1:0] word,
    input logic               upper,
    input logic [CPU_DW-1:0]  half
  );
    merge_half = upper ? {half, word[CPU_DW-1:0]} : {word[DRAM_DW-1:CPU_DW], half};
  endfunction

  function automatic logic [CPU_DW-1:0] select_half(
    input logic [DRAM_DW-1:0] word,
    input logic               upper
  );
    select_half = upper ? word[DRAM_DW-1:CPU_DW] : word[CPU_DW-1:0];
  endfunction

endpackage

// File: rtl/dram_word_buffer.sv
// dram_word_buffer
// Single-entry word cache in front of the SDRAM controller.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   load, load_addr, load_data   write the entry and mark it valid
//   clear            invalidate the entry (has priority over load)
//   lookup_addr      word address to compare against the entry tag
//   lookup_upper     half select for rd_half / merged
//   wdata            halfword merged into the entry copy
//   hit              entry valid and tag matches lookup_addr
//   rd_half          selected half of the stored word
//   merged           stored word with wdata merged into the selected half
module dram_word_buffer
  import dram_master_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DRAM_AW-1:0] load_addr,
  input  logic [DRAM_DW-1:0] load_data,
  input  logic               clear,
  input  logic [DRAM_AW-1:0] lookup_addr,
  input  logic               lookup_upper,
  input  logic [CPU_DW-1:0]  wdata,
  output logic               hit,
  output logic [CPU_DW-1:0]  rd_half,
  output logic [DRAM_DW-1:0] merged
);

  logic               buf_valid;
  logic [DRAM_AW-1:0] buf_addr;
  logic [DRAM_DW-1:0] buf_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        buf_valid <= 1'b0;
    else if (clear) buf_valid <= 1'b0;
    else if (load)  buf_valid <= 1'b1;
  end

  // NOTE: tag and data carry no reset; buf_valid alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (load) begin
      buf_addr <= load_addr;
      buf_data <= load_data;
    end
  end

  assign hit     = buf_valid && (buf_addr == lookup_addr);
  assign rd_half = select_half(buf_data, lookup_upper);
  assign merged  = merge_half(buf_data, lookup_upper, wdata);

endmodule

// File: rtl/dram_master.sv
// dram_master
// Converts d16 halfword read/write strobes into 32-bit SDRAM controller
// requests, with a one-word buffer and read-modify-write for halfword stores.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cpu_addr/cpu_rd/cpu_wr/cpu_wdata  core strobe side (sampled when not busy)
//   cpu_rdata/cpu_ack/cpu_err/cpu_busy  core response side (all registered)
//   dram_addr/dram_req_read/dram_req_write/dram_data_in  controller requests
//   dram_data_out/dram_data_valid    controller read return
module dram_master
  import dram_master_pkg::*;
#(
  parameter int WRITE_HOLD = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CPU_AW-1:0]  cpu_addr,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  input  logic [CPU_DW-1:0]  cpu_wdata,
  output logic [CPU_DW-1:0]  cpu_rdata,
  output logic               cpu_ack,
  output logic               cpu_err,
  output logic               cpu_busy,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_req_read,
  output logic               dram_req_write,
  output logic [DRAM_DW-1:0] dram_data_in,
  input  logic [DRAM_DW-1:0] dram_data_out,
  input  logic               dram_data_valid
);

  localparam int CNT_MAX = (TIMEOUT > WRITE_HOLD) ? TIMEOUT : WRITE_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state, next_state;
  logic [CNT_W-1:0]    wait_cnt;
  logic                half_q;
  logic [CPU_DW-1:0]   wdata_q;

  logic                accept_rd, accept_wr, fetch_done, timed_out, hold_done;
  logic                hit;
  logic [CPU_DW-1:0]   hit_half;
  logic [DRAM_DW-1:0]  hit_merged;

  dram_word_buffer u_buf (
    .clk          (clk),
    .rst          (rst),
    .load         (fetch_done || hold_done),
    .load_addr    (dram_addr),
    .load_data    (hold_done ? dram_data_in : dram_data_out),
    .clear        (timed_out),
    .lookup_addr  (cpu_addr[CPU_AW-1:1]),
    .lookup_upper (cpu_addr[0]),
    .wdata        (cpu_wdata),
    .hit          (hit),
    .rd_half      (hit_half),
    .merged       (hit_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    accept_rd  = 1'b0;
    accept_wr  = 1'b0;
    fetch_done = 1'b0;
    timed_out  = 1'b0;
    hold_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        // A write strobe wins over a simultaneous read, which is dropped.
        if (cpu_wr) begin
          accept_wr  = 1'b1;
          next_state = hit ? ST_WR_REQ : ST_WR_FETCH;
        end else if (cpu_rd) begin
          accept_rd  = 1'b1;
          next_state = hit ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ, ST_WR_FETCH: begin
        if (dram_data_valid) begin
          fetch_done = 1'b1;
          next_state = (state == ST_RD_REQ) ? ST_DONE : ST_WR_REQ;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          timed_out  = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_WR_REQ: begin
        if (wait_cnt == CNT_W'(WRITE_HOLD - 1)) begin
          hold_done  = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so each appears in the cycle the
  // FSM enters the corresponding state.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt       <= '0;
      half_q         <= 1'b0;
      wdata_q        <= '0;
      cpu_rdata      <= '0;
      cpu_ack        <= 1'b0;
      cpu_err        <= 1'b0;
      cpu_busy       <= 1'b0;
      dram_addr      <= '0;
      dram_req_read  <= 1'b0;
      dram_req_write <= 1'b0;
      dram_data_in   <= '0;
    end else begin
      cpu_ack        <= (next_state == ST_DONE);
      cpu_err        <= timed_out;
      cpu_busy       <= (next_state != ST_IDLE);
      dram_req_read  <= (next_state == ST_RD_REQ) || (next_state == ST_WR_FETCH);
      dram_req_write <= (next_state == ST_WR_REQ);

      // One counter serves both the fetch timeout and the write hold time.
      if (next_state == state && state != ST_IDLE && state != ST_DONE)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      if (accept_rd || accept_wr) begin
        dram_addr <= cpu_addr[CPU_AW-1:1];
        half_q    <= cpu_addr[0];
      end
      if (accept_wr) wdata_q <= cpu_wdata;

      if (accept_wr && hit)
        dram_data_in <= hit_merged;
      else if (fetch_done && state == ST_WR_FETCH)
        dram_data_in <= merge_half(dram_data_out, half_q, wdata_q);

      if (accept_rd && hit)
        cpu_rdata <= hit_half;
      else if (fetch_done && state == ST_RD_REQ)
        cpu_rdata <= select_half(dram_data_out, half_q);
      else if (timed_out)
        cpu_rdata <= RDATA_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_dram_master.sv
// tb_dram_master
// Directed bench for dram_master (WRITE_HOLD = 8, TIMEOUT = 16).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_dram_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [24:0] cpu_addr = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack, cpu_err, cpu_busy;
  logic [23:0] dram_addr;
  logic        dram_req_read, dram_req_write;
  logic [31:0] dram_data_in;
  logic [31:0] dram_data_out = '0;
  logic        dram_data_valid = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  dram_master #(.WRITE_HOLD(8), .TIMEOUT(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_addr        (cpu_addr),
    .cpu_rd          (cpu_rd),
    .cpu_wr          (cpu_wr),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_ack         (cpu_ack),
    .cpu_err         (cpu_err),
    .cpu_busy        (cpu_busy),
    .dram_addr       (dram_addr),
    .dram_req_read   (dram_req_read),
    .dram_req_write  (dram_req_write),
    .dram_data_in    (dram_data_in),
    .dram_data_out   (dram_data_out),
    .dram_data_valid (dram_data_valid)
  );

  always #10 clk = ~clk;

  // Request exclusivity holds in every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (dram_req_read && dram_req_write) begin
        n_fails++;
        $display("FAIL req_exclusive: read=%0b write=%0b expected not both high", dram_req_read, dram_req_write);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic rd, input logic wr, input logic [24:0] a, input logic [15:0] wd);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
    step();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({cpu_ack, cpu_err, cpu_busy, dram_req_read, dram_req_write} !== 5'b0) begin
      n_fails++; $display("FAIL reset_flags: got %b expected 00000", {cpu_ack, cpu_err, cpu_busy, dram_req_read, dram_req_write});
    end
    n_checks++;
    if ({cpu_rdata, dram_addr, dram_data_in} !== 72'h0) begin
      n_fails++; $display("FAIL reset_data: got %h expected 0", {cpu_rdata, dram_addr, dram_data_in});
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (cpu_busy !== 1'b0) begin
      n_fails++; $display("FAIL reset_idle_busy: got %b expected 0", cpu_busy);
    end
  endtask

  task automatic test_read_miss_hit();
    strobe(1'b1, 1'b0, 25'h000004, 16'h0);        // now N+1
    n_checks++;
    if (dram_req_read !== 1'b1 || cpu_busy !== 1'b1 || dram_addr !== 24'h000002) begin
      n_fails++; $display("FAIL rd_miss_req: req=%b busy=%b addr=%h expected 1 1 000002", dram_req_read, cpu_busy, dram_addr);
    end
    for (int i = 0; i < 4; i++) step();          // N+5
    dram_data_out = 32'hDEADBEEF; dram_data_valid = 1'b1;
    step();                                       // M+1
    dram_data_valid = 1'b0;
    n_checks++;
    if (cpu_ack !== 1'b1 || dram_req_read !== 1'b0 || cpu_err !== 1'b0 || cpu_rdata !== 16'hBEEF) begin
      n_fails++; $display("FAIL rd_miss_ack: ack=%b req=%b err=%b rdata=%h expected 1 0 0 beef", cpu_ack, dram_req_read, cpu_err, cpu_rdata);
    end
    step();
    n_checks++;
    if (cpu_ack !== 1'b0 || cpu_busy !== 1'b0) begin
      n_fails++; $display("FAIL rd_miss_after: ack=%b busy=%b expected 0 0", cpu_ack, cpu_busy);
    end
    strobe(1'b1, 1'b0, 25'h000005, 16'h0);        // hit, N+1
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hDEAD || dram_req_read !== 1'b0) begin
      n_fails++; $display("FAIL rd_hit: ack=%b rdata=%h req=%b expected 1 dead 0", cpu_ack, cpu_rdata, dram_req_read);
    end
    step();
  endtask

  task automatic test_write_miss_hit();
    int hi;
    bit acked;
    strobe(1'b0, 1'b1, 25'h000011, 16'h1234);     // N+1 = M
    n_checks++;
    if (dram_req_read !== 1'b1 || dram_req_write !== 1'b0) begin
      n_fails++; $display("FAIL wr_miss_fetch: rd=%b wr=%b expected 1 0", dram_req_read, dram_req_write);
    end
    dram_data_out = 32'hAAAA5555; dram_data_valid = 1'b1;
    step();                                       // M+1
    dram_data_valid = 1'b0;
    n_checks++;
    if (dram_req_write !== 1'b1 || dram_req_read !== 1'b0 || dram_data_in !== 32'h12345555) begin
      n_fails++; $display("FAIL wr_miss_word: wr=%b rd=%b data=%h expected 1 0 12345555", dram_req_write, dram_req_read, dram_data_in);
    end
    hi = 0; acked = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      if (dram_req_write) hi++;
      if (cpu_ack) acked = 1'b1;
      else step();
    end
    n_checks++;
    if (!acked || hi != 8 || dram_req_write !== 1'b0) begin
      n_fails++; $display("FAIL wr_miss_hold: acked=%b cycles=%0d req=%b expected 1 8 0", acked, hi, dram_req_write);
    end
    step();
    strobe(1'b1, 1'b0, 25'h000011, 16'h0);        // buffer holds merged word
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h1234 || dram_req_read !== 1'b0) begin
      n_fails++; $display("FAIL wr_buf_merged: ack=%b rdata=%h req=%b expected 1 1234 0", cpu_ack, cpu_rdata, dram_req_read);
    end
    step();
    strobe(1'b0, 1'b1, 25'h000010, 16'h7777);     // write hit, N+1
    n_checks++;
    if (dram_req_write !== 1'b1 || dram_req_read !== 1'b0 || dram_data_in !== 32'h12347777) begin
      n_fails++; $display("FAIL wr_hit_word: wr=%b rd=%b data=%h expected 1 0 12347777", dram_req_write, dram_req_read, dram_data_in);
    end
    hi = 0; acked = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      if (dram_req_write) hi++;
      if (dram_req_read) hi = 100;
      if (cpu_ack) acked = 1'b1;
      else step();
    end
    n_checks++;
    if (!acked || hi != 8) begin
      n_fails++; $display("FAIL wr_hit_hold: acked=%b cycles=%0d expected 1 8", acked, hi);
    end
    step();
  endtask

  task automatic test_ignored_inputs();
    int acks;
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 25'h000010; cpu_wdata = 16'h4321;
    step();                                       // N+1, busy
    cpu_wr = 1'b0;                                // cpu_rd stays high: strobe while busy
    n_checks++;
    if (cpu_ack !== 1'b0 || dram_req_write !== 1'b1 || dram_data_in !== 32'h12344321) begin
      n_fails++; $display("FAIL rdwr_write_wins: ack=%b wr=%b data=%h expected 0 1 12344321", cpu_ack, dram_req_write, dram_data_in);
    end
    step();
    cpu_rd = 1'b0;
    acks = 0;
    for (int i = 0; i < 14; i++) begin
      if (cpu_ack) acks++;
      if (dram_req_read) acks = 100;
      step();
    end
    n_checks++;
    if (acks != 1) begin
      n_fails++; $display("FAIL busy_strobe_ignored: acks=%0d expected 1", acks);
    end
    dram_data_out = 32'h99999999; dram_data_valid = 1'b1;
    step();
    dram_data_valid = 1'b0;
    step();
    strobe(1'b1, 1'b0, 25'h000011, 16'h0);
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h1234 || dram_req_read !== 1'b0) begin
      n_fails++; $display("FAIL stray_valid: ack=%b rdata=%h req=%b expected 1 1234 0", cpu_ack, cpu_rdata, dram_req_read);
    end
    step();
  endtask

  task automatic test_reset_mid_write();
    strobe(1'b0, 1'b1, 25'h000010, 16'h5A5A);     // write hit
    step(); step();                               // inside WR_REQ
    n_checks++;
    if (dram_req_write !== 1'b1) begin
      n_fails++; $display("FAIL rst_mid_pre: wr=%b expected 1", dram_req_write);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (dram_req_write !== 1'b0 || cpu_busy !== 1'b0 || cpu_ack !== 1'b0) begin
      n_fails++; $display("FAIL rst_mid_async: wr=%b busy=%b ack=%b expected 0 0 0", dram_req_write, cpu_busy, cpu_ack);
    end
    step();
    rst = 1'b0;
    step();
    strobe(1'b1, 1'b0, 25'h000010, 16'h0);
    n_checks++;
    if (dram_req_read !== 1'b1 || cpu_ack !== 1'b0) begin
      n_fails++; $display("FAIL rst_mid_miss: req=%b ack=%b expected 1 0", dram_req_read, cpu_ack);
    end
    dram_data_out = 32'h0000ABCD; dram_data_valid = 1'b1;
    step();
    dram_data_valid = 1'b0;
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hABCD) begin
      n_fails++; $display("FAIL rst_mid_refill: ack=%b rdata=%h expected 1 abcd", cpu_ack, cpu_rdata);
    end
    step();
  endtask

  task automatic test_timeout();
    int hi;
    bit dropped;
    strobe(1'b1, 1'b0, 25'h000100, 16'h0);        // N+1
    hi = 0; dropped = 1'b0;
    for (int i = 0; i < 40 && !dropped; i++) begin
      if (dram_req_read) begin
        hi++;
        step();
      end else dropped = 1'b1;
    end
    n_checks++;
    if (!dropped || hi != 16) begin
      n_fails++; $display("FAIL timeout_len: dropped=%b cycles=%0d expected 1 16", dropped, hi);
    end
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 16'hFFFF) begin
      n_fails++; $display("FAIL timeout_resp: ack=%b err=%b rdata=%h expected 1 1 ffff", cpu_ack, cpu_err, cpu_rdata);
    end
    step();
    strobe(1'b1, 1'b0, 25'h000100, 16'h0);
    n_checks++;
    if (dram_req_read !== 1'b1 || cpu_ack !== 1'b0) begin
      n_fails++; $display("FAIL timeout_then_miss: req=%b ack=%b expected 1 0", dram_req_read, cpu_ack);
    end
    dram_data_out = 32'h0BADCAFE; dram_data_valid = 1'b1;
    step();
    dram_data_valid = 1'b0;
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 16'hCAFE) begin
      n_fails++; $display("FAIL timeout_recover: ack=%b err=%b rdata=%h expected 1 0 cafe", cpu_ack, cpu_err, cpu_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_miss_hit();
    test_ignored_inputs();
    test_reset_mid_write();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
